// File: rtl/muldiv_sequencer_if.sv
// Operation encoding and the issue/result bundle between the decoder/hazard
// logic and the HI/LO multiply/divide sequencer.
package selector;
  typedef enum logic [3:0] {
    NOP   = 4'd0,
    MULT  = 4'd1,
    MULTU = 4'd2,
    MADD  = 4'd3,
    MADDU = 4'd4,
    MSUB  = 4'd5,
    MSUBU = 4'd6,
    MUL   = 4'd7,
    DIV   = 4'd8,
    DIVU  = 4'd9
  } muldiv_funct_t;
endpackage

interface muldiv_sequencer_if;
  logic                    start;
  selector::muldiv_funct_t funct;
  logic [31:0]             rs_val;
  logic [31:0]             rt_val;
  logic                    write_hi;
  logic                    write_lo;
  logic [31:0]             wdata;
  logic                    flush;
  logic                    busy;
  logic                    done;
  logic [31:0]             mul_result;
  logic [31:0]             hi;
  logic [31:0]             lo;

  modport master (
    output start, funct, rs_val, rt_val, write_hi, write_lo, wdata, flush,
    input  busy, done, mul_result, hi, lo
  );

  modport slave (
    input  start, funct, rs_val, rt_val, write_hi, write_lo, wdata, flush,
    output busy, done, mul_result, hi, lo
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// HI/LO multiply/divide sequencer: fixed-latency multiply, 32-step restoring
// divide with sign fix-up, MTHI/MTLO writes and flush cancellation.
module muldiv_sequencer #(
  parameter int unsigned MUL_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  muldiv_sequencer_if.slave bus
);
  import selector::*;

  localparam int unsigned CNT_W    = ($clog2(MUL_CYCLES) > 5) ? $clog2(MUL_CYCLES) : 5;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(31);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MUL_RUN = 2'd1,
    S_DIV_RUN = 2'd2,
    S_DIV_FIX = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  muldiv_funct_t   funct_q, funct_d;
  logic [31:0]     rs_q, rs_d;
  logic [63:0]     prod_q, prod_d;
  logic [31:0]     rem_q, rem_d;
  logic [31:0]     quo_q, quo_d;
  logic [31:0]     dvsr_q, dvsr_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic            dz_q, dz_d;
  logic [31:0]     hi_q, hi_d;
  logic [31:0]     lo_q, lo_d;
  logic [31:0]     mulres_q, mulres_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic        is_mul, is_div, is_signed, accept;
  logic [63:0] op_a, op_b, product;
  logic [31:0] dvnd_mag, dvsr_mag;
  logic [32:0] rem_shift;
  logic [33:0] trial;

  // Operation class decode
  always_comb begin
    is_mul    = 1'b0;
    is_div    = 1'b0;
    is_signed = 1'b0;
    case (bus.funct)
      MULT, MADD, MSUB, MUL: begin is_mul = 1'b1; is_signed = 1'b1; end
      MULTU, MADDU, MSUBU:   is_mul = 1'b1;
      DIV:                   begin is_div = 1'b1; is_signed = 1'b1; end
      DIVU:                  is_div = 1'b1;
      default: ;
    endcase
  end

  assign accept = (state_q == S_IDLE) && bus.start && (is_mul || is_div) && !bus.flush;

  // Low 64 bits of the extended product are correct for both signednesses
  assign op_a    = {{32{is_signed & bus.rs_val[31]}}, bus.rs_val};
  assign op_b    = {{32{is_signed & bus.rt_val[31]}}, bus.rt_val};
  assign product = op_a * op_b;

  assign dvnd_mag = (is_signed && bus.rs_val[31]) ? (~bus.rs_val + 32'd1) : bus.rs_val;
  assign dvsr_mag = (is_signed && bus.rt_val[31]) ? (~bus.rt_val + 32'd1) : bus.rt_val;

  // One restoring step: shift in next dividend bit, subtract if it fits
  assign rem_shift = {rem_q, quo_q[31]};
  assign trial     = {1'b0, rem_shift} - {2'b00, dvsr_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    funct_d  = funct_q;
    rs_d     = rs_q;
    prod_d   = prod_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    mulres_d = mulres_q;
    done_d   = 1'b0;

    if (bus.flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            funct_d = bus.funct;
            rs_d    = bus.rs_val;
            if (is_mul) begin
              prod_d  = product;
              cnt_d   = MUL_LOAD;
              state_d = S_MUL_RUN;
            end else begin
              quo_d   = dvnd_mag;
              dvsr_d  = dvsr_mag;
              rem_d   = '0;
              qneg_d  = is_signed && (bus.rs_val[31] ^ bus.rt_val[31]);
              rneg_d  = is_signed && bus.rs_val[31];
              dz_d    = (bus.rt_val == 32'd0);
              cnt_d   = DIV_LOAD;
              state_d = S_DIV_RUN;
            end
          end else begin
            if (bus.write_hi) hi_d = bus.wdata;
            if (bus.write_lo) lo_d = bus.wdata;
          end
        end
        S_MUL_RUN: begin
          if (cnt_q == '0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            case (funct_q)
              MULT, MULTU: {hi_d, lo_d} = prod_q;
              MADD, MADDU: {hi_d, lo_d} = {hi_q, lo_q} + prod_q;
              MSUB, MSUBU: {hi_d, lo_d} = {hi_q, lo_q} - prod_q;
              MUL:         mulres_d = prod_q[31:0];
              default: ;
            endcase
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_DIV_RUN: begin
          if (!trial[33]) begin
            rem_d = trial[31:0];
            quo_d = {quo_q[30:0], 1'b1};
          end else begin
            rem_d = rem_shift[31:0];
            quo_d = {quo_q[30:0], 1'b0};
          end
          if (cnt_q == '0) state_d = S_DIV_FIX;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        S_DIV_FIX: begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          if (dz_q) begin
            lo_d = 32'hFFFF_FFFF;
            hi_d = rs_q;
          end else begin
            lo_d = qneg_q ? (~quo_q + 32'd1) : quo_q;
            hi_d = rneg_q ? (~rem_q + 32'd1) : rem_q;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign busy_d = (state_d != S_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      funct_q  <= NOP;
      rs_q     <= '0;
      prod_q   <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      mulres_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      funct_q  <= funct_d;
      rs_q     <= rs_d;
      prod_q   <= prod_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      mulres_q <= mulres_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.mul_result = mulres_q;
  assign bus.hi         = hi_q;
  assign bus.lo         = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: expected commits are queued at issue
// and checked by a monitor on every done pulse.
module tb_muldiv_sequencer;
  import selector::*;

  localparam int unsigned MUL_CYCLES = 4;
  localparam int unsigned DIV_LAT    = 33;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mr;
    bit          chk_mr;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb[$];

  muldiv_sequencer_if bus ();

  muldiv_sequencer #(.MUL_CYCLES(MUL_CYCLES)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expectation
  always @(negedge clk) begin
    if (reset_n === 1'b1 && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=done required=no_done (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_hi"}, bus.hi, e.hi);
        chk({e.name, "_lo"}, bus.lo, e.lo);
        if (e.chk_mr) chk({e.name, "_mul_result"}, bus.mul_result, e.mr);
      end
    end
  end

  task automatic expect_res(input string nm, input logic [31:0] h, input logic [31:0] l,
                            input logic [31:0] m, input bit cm);
    exp_t e;
    e.name = nm; e.hi = h; e.lo = l; e.mr = m; e.chk_mr = cm;
    sb.push_back(e);
  endtask

  task automatic issue(input muldiv_funct_t f, input logic [31:0] a, input logic [31:0] b);
    bus.start  = 1'b1;
    bus.funct  = f;
    bus.rs_val = a;
    bus.rt_val = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic mt(input bit wh, input bit wl, input logic [31:0] d);
    bus.write_hi = wh;
    bus.write_lo = wl;
    bus.wdata    = d;
    @(posedge clk); #1;
    bus.write_hi = 1'b0;
    bus.write_lo = 1'b0;
  endtask

  // Waits for done (bounded) and checks how many busy cycles preceded it
  task automatic wait_done(input string nm, input int exp_busy);
    int n = 0;
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen = 1'b1;
      else if (bus.busy === 1'b1) n++;
    end
    chk({nm, "_done_seen"}, 32'(seen), 32'd1);
    if (seen && exp_busy >= 0) chk({nm, "_busy_cycles"}, 32'(n), 32'(exp_busy));
  endtask

  initial begin
    int n;
    int nd;
    int t1;
    int t2;
    bus.start = 1'b0; bus.funct = NOP; bus.rs_val = '0; bus.rt_val = '0;
    bus.write_hi = 1'b0; bus.write_lo = 1'b0; bus.wdata = '0; bus.flush = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_hi", bus.hi, 32'd0);
    chk("reset_lo", bus.lo, 32'd0);
    chk("reset_mul_result", bus.mul_result, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    expect_res("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE, '0, 1'b0);
    issue(MULT, 32'hFFFF_FFFF, 32'd2);
    wait_done("mult", MUL_CYCLES);
    expect_res("multu", 32'h1, 32'hFFFF_FFFE, '0, 1'b0);
    issue(MULTU, 32'hFFFF_FFFF, 32'd2);
    wait_done("multu", MUL_CYCLES);

    mt(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    chk("mthi", bus.hi, 32'h0);
    mt(1'b0, 1'b1, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("mtlo", bus.lo, 32'hFFFF_FFFF);
    expect_res("maddu", 32'h1, 32'h0, '0, 1'b0);
    issue(MADDU, 32'd1, 32'd1);
    wait_done("maddu", MUL_CYCLES);

    mt(1'b1, 1'b1, 32'h0);
    @(negedge clk);
    chk("mt_both_hi", bus.hi, 32'h0);
    chk("mt_both_lo", bus.lo, 32'h0);
    expect_res("msub", 32'hFFFF_FFFF, 32'hFFFF_FFFE, '0, 1'b0);
    issue(MSUB, 32'd1, 32'd2);
    wait_done("msub", MUL_CYCLES);
    expect_res("mul", 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFF1, 1'b1);
    issue(MUL, 32'd3, 32'hFFFF_FFFB);
    wait_done("mul", MUL_CYCLES);

    expect_res("div_neg7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, '0, 1'b0);
    issue(DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_neg7_2", DIV_LAT);
    expect_res("divu_7_2", 32'h1, 32'h3, '0, 1'b0);
    issue(DIVU, 32'd7, 32'd2);
    wait_done("divu_7_2", DIV_LAT);
    expect_res("div_min_m1", 32'h0, 32'h8000_0000, '0, 1'b0);
    issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_min_m1", DIV_LAT);
    expect_res("divu_by0", 32'h5, 32'hFFFF_FFFF, '0, 1'b0);
    issue(DIVU, 32'd5, 32'd0);
    wait_done("divu_by0", DIV_LAT);

    // Flush on the 10th busy cycle of a divide
    issue(DIV, 32'd100, 32'd7);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) n++;
      if (n == 10) break;
    end
    chk("flush_reach_10", 32'(n), 32'd10);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", 32'(bus.busy), 32'd0);
    chk("flush_done", 32'(bus.done), 32'd0);
    chk("flush_hi", bus.hi, 32'h5);
    chk("flush_lo", bus.lo, 32'hFFFF_FFFF);
    expect_res("mult_after_flush", 32'h0, 32'd12, '0, 1'b0);
    issue(MULT, 32'd3, 32'd4);
    wait_done("mult_after_flush", MUL_CYCLES);

    // Flush coincident with start: nothing accepted
    bus.flush = 1'b1;
    issue(MULT, 32'd9, 32'd9);
    bus.flush = 1'b0;
    @(negedge clk);
    chk("flush_start_busy", 32'(bus.busy), 32'd0);
    nd = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done === 1'b1) nd++;
    end
    chk("flush_start_no_done", 32'(nd), 32'd0);
    chk("flush_start_lo", bus.lo, 32'd12);

    // MTLO while busy is ignored
    expect_res("mtlo_busy", 32'h0, 32'd6, '0, 1'b0);
    issue(MULT, 32'd2, 32'd3);
    @(negedge clk);
    mt(1'b0, 1'b1, 32'hDEAD_BEEF);
    wait_done("mtlo_busy", MUL_CYCLES - 1);

    // Asynchronous reset mid-MADD
    issue(MADD, 32'd5, 32'd5);
    @(negedge clk);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(bus.busy), 32'd0);
    chk("rst_mid_done", 32'(bus.done), 32'd0);
    chk("rst_mid_hi", bus.hi, 32'd0);
    chk("rst_mid_lo", bus.lo, 32'd0);
    chk("rst_mid_mul_result", bus.mul_result, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    expect_res("multu_after_rst", 32'h0, 32'd42, '0, 1'b0);
    issue(MULTU, 32'd7, 32'd6);
    wait_done("multu_after_rst", MUL_CYCLES);

    // Back-to-back issue in the done cycle
    expect_res("b2b_first", 32'h0, 32'd4, '0, 1'b0);
    issue(MULT, 32'd2, 32'd2);
    wait_done("b2b_first", MUL_CYCLES);
    t1 = cyc;
    expect_res("b2b_second", 32'h0, 32'd1, '0, 1'b0);
    issue(MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("b2b_second", MUL_CYCLES);
    t2 = cyc;
    chk("b2b_done_spacing", 32'(t2 - t1), 32'(MUL_CYCLES + 1));

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle controller for the HI/LO multiply/divide resource in the execute stage. It accepts one MULT/MULTU/MADD/MADDU/MSUB/MSUBU/MUL/DIV/DIVU operation at a time from the decoder's `muldiv_funct`, sequences it through a fixed-latency multiplier or a radix-2 restoring divider, and commits results to its HI/LO registers or, for MUL, to a GPR result port. It drives the stall signal the hazard unit uses to hold MFHI/MFLO and new mul/div issues, and supports cancellation by a later-stage exception flush.

## Interface
- `MUL_CYCLES`, default 4: multiply latency in cycles, ≥1.
- `clk`  in  1  clock, rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `start`  in  1  issue request, sampled only in IDLE.
- `funct`  in  `selector::muldiv_funct_t`  operation: MULT, MULTU, MADD, MADDU, MSUB, MSUBU, MUL, DIV, DIVU. Any other value with `start` is a no-op.
- `rs_val`  in  32  operand A / dividend.
- `rt_val`  in  32  operand B / divisor.
- `write_hi`, `write_lo`  in  1 each  MTHI/MTLO strobes.
- `wdata`  in  32  MTHI/MTLO data.
- `flush`  in  1  cancels the in-flight op and any same-cycle request.
- `busy`  out  1  operation in flight; hazard unit stalls on it.
- `done`  out  1  one-cycle completion pulse.
- `mul_result`  out  32  MUL low word, valid while `done`.
- `hi`, `lo`  out  32 each  architectural HI/LO.

## Operation
- States: IDLE, MUL_RUN, DIV_RUN, DIV_FIX.
- IDLE + `start` + valid funct + !`flush`:
  - Latch funct and operands.
  - Multiply ops: register the 64-bit product and go to MUL_RUN. Signed ops sign-extend; MULTU/MADDU/MSUBU zero-extend. Counter = MUL_CYCLES-1.
  - DIV/DIVU: load the operand magnitudes (DIV) or raw operands (DIVU) and go to DIV_RUN. Counter = 31.
- MUL_RUN: decrement the counter. At 0, commit and return to IDLE.
  - MULT/MULTU: {hi,lo}=p.
  - MADD/MADDU: {hi,lo}+=p.
  - MSUB/MSUBU: {hi,lo}-=p. 64-bit, wrap modulo 2^64.
  - MUL: `mul_result`=p[31:0]; HI/LO unchanged.
- DIV_RUN: one restoring step per cycle; after 32 steps go to DIV_FIX.
- DIV_FIX: for DIV, negate the quotient if operand signs differ; the remainder takes the dividend's sign. Commit lo=quotient, hi=remainder, then go to IDLE.
- Divide by zero (rt=0, DIV or DIVU): runs full length; commits lo=32'hFFFF_FFFF, hi=rs_val.
- MTHI/MTLO: applied at the next edge only in IDLE with no accepted `start` that cycle. Ignored while `busy` or when coincident with an accepted `start`. Both strobes together write both registers.
- `flush`, in any state: next edge goes to IDLE with no commit, no `done`, and HI/LO/`mul_result` unchanged. It also suppresses a same-cycle `start` or MTHI/MTLO. A flush in the final busy cycle cancels that commit.
- `start` while `busy`: ignored; upstream guarantees it is held.
- Reset, including mid-operation: state IDLE; hi=0, lo=0, mul_result=0, busy=0, done=0; internal counters and registers cleared.

## Timing
- Acceptance edge E0. Latency L = MUL_CYCLES for multiply ops, 33 for divides (32 steps + fix).
- `busy` is registered: high in the L cycles after E0, low otherwise.
- Commit at edge E_L: new hi/lo visible and `done`=1 in the cycle after E_L, with `busy`=0 that cycle. A new `start` is accepted at E_{L+1}.
- Back-to-back: `start` is accepted in the same cycle `done` is high.
- MTHI/MTLO: hi/lo updated one edge after the strobe.
- `busy` does not depend combinationally on `start`; the hazard unit covers the issue cycle itself.

## Test plan
- MULT rs=0xFFFFFFFF rt=2, MUL_CYCLES=4:
  - `busy` high 4 cycles, then `done`.
  - hi=0xFFFFFFFF, lo=0xFFFFFFFE.
  - MULTU with the same operands gives hi=0x1, lo=0xFFFFFFFE.
- Accumulate:
  - MTHI 0, MTLO 0xFFFFFFFF, then MADDU 1×1 → hi=0x1, lo=0x0.
  - From 0/0, MSUB 1×2 → hi=0xFFFFFFFF, lo=0xFFFFFFFE.
  - MUL 3×(-5) → mul_result=0xFFFFFFF1, hi/lo unchanged.
- Divide:
  - DIV -7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; `busy` exactly 33 cycles.
  - DIVU 7/2 → lo=3, hi=1.
  - DIV 0x80000000/-1 → lo=0x80000000, hi=0.
- DIVU 5/0 → lo=0xFFFFFFFF, hi=5 after 33 cycles.
- Cancellation and overlap:
  - `flush` on the 10th busy cycle of DIV → `busy` low next cycle, no `done`, hi/lo unchanged; a new MULT the following cycle completes normally.
  - `flush` coincident with `start` → nothing accepted.
  - MTLO while busy → ignored.
- Reset and back-to-back:
  - `reset_n` low mid-MADD → all outputs 0 immediately; after release, IDLE accepts `start`.
  - Back-to-back MULT issued in the `done` cycle → second `done` exactly MUL_CYCLES+1 cycles after the first.
